// File: rtl/uart_imem_loader_pkg.sv
// rtl/uart_imem_loader_pkg.sv - state encodings, ack bytes and address helper for the IMEM loader
package uart_imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CNT_LO = 3'd1;
  localparam state_t S_CNT_HI = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_CSUM   = 3'd4;
  localparam state_t S_ACK    = 3'd5;

  localparam logic [7:0] ACK_BYTE          = 8'h06;
  localparam logic [7:0] NAK_BYTE          = 8'h15;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// rtl/uart_imem_loader_if.sv - rx byte stream, IMEM write bus and optional ack channel (LOADER_ACK_EN)
interface uart_imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
`ifdef LOADER_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`endif

  modport master (
    input  rx_data, rx_valid,
    output imem_we, imem_addr, imem_wd
`ifdef LOADER_ACK_EN
    , output tx_data, tx_valid,
    input  tx_ready
`endif
  );

  modport slave (
    output rx_data, rx_valid,
    input  imem_we, imem_addr, imem_wd
`ifdef LOADER_ACK_EN
    , input tx_data, tx_valid,
    output tx_ready
`endif
  );
endinterface

// File: rtl/uart_imem_loader_timeout.sv
// rtl/uart_imem_loader_timeout.sv - inter-byte silence counter with saturating expiry flag
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK) begin
    if (!RST_N || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - framed UART program loader driving IMEM writes; LOADER_ACK_EN adds ack/nak byte
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS     = 64,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  uart_imem_loader_if.master   bus,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 busy
);
  state_t      state;
  logic [15:0] cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic        to_en;
  logic        to_exp;
  logic        timed_out;
  logic [15:0] cnt_full;
  logic        bad_cnt;
  logic        finish;
  logic        good;

  assign busy          = (state != S_IDLE);
  assign bus.imem_we   = we_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_wd   = wd_q;

  // The ack wait is bounded by the host, not by the inter-byte timeout.
  assign to_en     = (state != S_IDLE) && (state != S_ACK);
  assign timed_out = to_en && to_exp && !bus.rx_valid;
  assign cnt_full  = {bus.rx_data, cnt[7:0]};
  assign bad_cnt   = (cnt_full == 16'd0) || (cnt_full > 16'(IMEM_WORDS));
  assign good      = (state == S_CSUM) && bus.rx_valid && (bus.rx_data == csum);
  assign finish    = timed_out
                   || ((state == S_CNT_HI) && bus.rx_valid && bad_cnt)
                   || ((state == S_CSUM) && bus.rx_valid);

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (bus.rx_valid || !to_en),
    .en      (to_en),
    .expired (to_exp)
  );

`ifdef LOADER_ACK_EN
  logic ack_good;
  assign bus.tx_valid = (state == S_ACK);
  assign bus.tx_data  = ack_good ? ACK_BYTE : NAK_BYTE;
  assign load_done    = (state == S_ACK) && bus.tx_ready && ack_good;
  assign load_err     = (state == S_ACK) && bus.tx_ready && !ack_good;
`else
  logic done_q;
  logic err_q;
  assign load_done = done_q;
  assign load_err  = err_q;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      csum     <= '0;
      we_q     <= 1'b0;
      addr_q   <= BASE_ADDR;
      wd_q     <= '0;
      cpu_hold <= 1'b0;
`ifdef LOADER_ACK_EN
      ack_good <= 1'b0;
`else
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
`ifndef LOADER_ACK_EN
      done_q <= 1'b0;
      err_q  <= 1'b0;
`endif
      if (finish) begin
`ifdef LOADER_ACK_EN
        state    <= S_ACK;
        ack_good <= good;
`else
        state  <= S_IDLE;
        done_q <= good;
        err_q  <= !good;
        if (good) cpu_hold <= 1'b0;
`endif
      end else if (state == S_ACK) begin
`ifdef LOADER_ACK_EN
        if (bus.tx_ready) begin
          state <= S_IDLE;
          if (ack_good) cpu_hold <= 1'b0;
        end
`else
        state <= S_IDLE;
`endif
      end else if (bus.rx_valid) begin
        case (state)
          S_IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              cpu_hold <= 1'b1;
              csum     <= '0;
              word_idx <= '0;
              byte_cnt <= '0;
              state    <= S_CNT_LO;
            end
          end
          S_CNT_LO: begin
            cnt[7:0] <= bus.rx_data;
            state    <= S_CNT_HI;
          end
          S_CNT_HI: begin
            cnt[15:8] <= bus.rx_data;
            state     <= S_DATA;
          end
          S_DATA: begin
            csum <= csum ^ bus.rx_data;
            if (byte_cnt == 2'd3) begin
              we_q     <= 1'b1;
              addr_q   <= word_addr(BASE_ADDR, word_idx);
              wd_q     <= {bus.rx_data, word_buf};
              word_idx <= word_idx + 16'd1;
              byte_cnt <= '0;
              if (word_idx == cnt - 16'd1) state <= S_CSUM;
            end else begin
              word_buf[8*byte_cnt +: 8] <= bus.rx_data;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
